// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
//   Round-robin arbiter in front of a bank of SR status flags. Each requester
//   presents a set/clear command against one flag index. One command is
//   granted per cycle, so a flag can never see set and clear together, and
//   the winning command is applied to the flag bank in the grant cycle.
//
// Optional feature macro: SR_FLAG_ARB_CONFLICT_CNT_EN
//   Defined   : conflict_cnt counts cycles with an opposite-op, same-index
//               collision among eligible requesters (saturates at 255).
//   Undefined : conflict_cnt is tied to zero; no detection logic is built.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   req          in   [NUM_REQ]        per-requester command request
//   req_op       in   [NUM_REQ]        1 = set, 0 = clear
//   req_idx      in   [NUM_REQ*IDX_W]  requester k uses [k*IDX_W +: IDX_W]
//   clear_all    in   clear every flag at the next edge (blocks grants)
//   gnt          out  [NUM_REQ]        registered one-hot grant pulse
//   flags        out  [NUM_FLAGS]      flag state (Q)
//   flags_b      out  [NUM_FLAGS]      complement of flags (Q-bar)
//   conflict_cnt out  [8]              collision cycle counter

module sr_flag_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FLAGS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    input  logic                     clear_all,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_FLAGS-1:0]     flags,
    output logic [NUM_FLAGS-1:0]     flags_b,
    output logic [7:0]               conflict_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [NUM_REQ-1:0]   elig;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_d;
    logic [PTR_W-1:0]     win;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_op;
    logic [NUM_FLAGS-1:0] flags_q;
    logic [NUM_FLAGS-1:0] flags_d;

    // A requester granted this cycle is masked so a held request is not
    // issued twice for the same command.
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && elig[(int'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
        win_idx = req_idx[int'(win)*IDX_W +: IDX_W];
        win_op  = req_op[win];
    end

    // clear_all blocks the grant and holds ptr; pending requests retry.
    // An index outside the bank matches no flag, so the grant has no effect.
    always_comb begin
        gnt_d   = '0;
        ptr_d   = ptr_q;
        flags_d = flags_q;
        if (clear_all) begin
            flags_d = '0;
        end else if (found) begin
            gnt_d[win] = 1'b1;
            ptr_d      = (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);
            for (int f = 0; f < NUM_FLAGS; f++) begin
                if (win_idx == IDX_W'(f)) begin
                    flags_d[f] = win_op;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q   <= '0;
            ptr_q   <= '0;
            flags_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            flags_q <= flags_d;
        end
    end

    assign gnt     = gnt_q;
    assign flags   = flags_q;
    assign flags_b = ~flags_q;

`ifdef SR_FLAG_ARB_CONFLICT_CNT_EN
    logic       collide;
    logic [7:0] cnt_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Collision: any pair of eligible requesters on one index with opposite
    // ops. Counted regardless of clear_all, which does not clear the count.
    always_comb begin
        collide = 1'b0;
        for (int a = 0; a < NUM_REQ; a++) begin
            for (int b = a + 1; b < NUM_REQ; b++) begin
                if (elig[a] && elig[b] &&
                    (req_idx[a*IDX_W +: IDX_W] == req_idx[b*IDX_W +: IDX_W]) &&
                    (req_op[a] != req_op[b])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (collide) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter
//   Directed-vector bench for sr_flag_arbiter (NUM_REQ=4, NUM_FLAGS=8,
//   IDX_W=3). Expected values are hand-computed per vector.

module tb_sr_flag_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_op;
    logic [11:0] req_idx;
    logic       clear_all;
    logic [3:0] gnt;
    logic [7:0] flags;
    logic [7:0] flags_b;
    logic [7:0] conflict_cnt;

    int n_vec;
    int n_err;
    int pulses;

`ifdef SR_FLAG_ARB_CONFLICT_CNT_EN
    localparam logic [7:0] EXP_CNT = 8'd1;
`else
    localparam logic [7:0] EXP_CNT = 8'd0;
`endif

    sr_flag_arbiter #(
        .NUM_REQ  (4),
        .NUM_FLAGS(8),
        .IDX_W    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_op      (req_op),
        .req_idx     (req_idx),
        .clear_all   (clear_all),
        .gnt         (gnt),
        .flags       (flags),
        .flags_b     (flags_b),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        clear_all = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [7:0] exp);
        chk({tag, "_flags"}, {24'd0, flags}, {24'd0, exp});
        chk({tag, "_flags_b"}, {24'd0, flags_b}, {24'd0, ~exp});
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req       = '0;
        req_op    = '0;
        req_idx   = '0;
        clear_all = 1'b0;

        // Reset, single command
        step();
        step();
        chk("rst_gnt", {28'd0, gnt}, 32'h0);
        chk_flags("rst", 8'h00);
        chk("rst_cnt", {24'd0, conflict_cnt}, 32'h0);
        reset   = 1'b0;
        req     = 4'b0001;
        req_op  = 4'b0001;
        req_idx = {3'd0, 3'd0, 3'd0, 3'd5};
        chk_flags("pre_gnt", 8'h00);
        step();
        chk("single_gnt", {28'd0, gnt}, 32'h1);
        chk_flags("single", 8'h20);
        req = '0;

        // Round-robin order, each requester drops after its grant
        do_reset();
        req     = 4'b1111;
        req_op  = 4'b1111;
        req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        step();
        chk("rr_gnt0", {28'd0, gnt}, 32'h1);
        chk_flags("rr0", 8'h01);
        req = 4'b1110;
        step();
        chk("rr_gnt1", {28'd0, gnt}, 32'h2);
        chk_flags("rr1", 8'h03);
        req = 4'b1100;
        step();
        chk("rr_gnt2", {28'd0, gnt}, 32'h4);
        chk_flags("rr2", 8'h07);
        req = 4'b1000;
        step();
        chk("rr_gnt3", {28'd0, gnt}, 32'h8);
        chk_flags("rr3", 8'h0F);
        req = '0;

        // Set/clear collision on index 2
        do_reset();
        req     = 4'b0011;
        req_op  = 4'b0001;
        req_idx = {3'd0, 3'd0, 3'd2, 3'd2};
        step();
        chk("col_gnt0", {28'd0, gnt}, 32'h1);
        chk_flags("col0", 8'h04);
        chk("col_cnt0", {24'd0, conflict_cnt}, {24'd0, EXP_CNT});
        req = 4'b0010;
        step();
        chk("col_gnt1", {28'd0, gnt}, 32'h2);
        chk_flags("col1", 8'h00);
        chk("col_cnt1", {24'd0, conflict_cnt}, {24'd0, EXP_CNT});
        req = '0;

        // clear_all contention: fill the bank, then clear with req2 pending
        do_reset();
        for (int k = 0; k < 8; k++) begin
            req     = 4'b0001;
            req_op  = 4'b0001;
            req_idx = {3'd0, 3'd0, 3'd0, 3'(k)};
            step();
            req = '0;
            step();
        end
        chk_flags("fill", 8'hFF);
        req       = 4'b0100;
        req_op    = 4'b0100;
        req_idx   = {3'd0, 3'd0, 3'd0, 3'd0};
        clear_all = 1'b1;
        step();
        chk("clr_gnt", {28'd0, gnt}, 32'h0);
        chk_flags("clr", 8'h00);
        clear_all = 1'b0;
        step();
        chk("clr_after_gnt", {28'd0, gnt}, 32'h4);
        chk_flags("clr_after", 8'h01);
        req = '0;
        step();

        // Held request: req3 clears idx 0 for 6 sampled edges
        req     = 4'b1000;
        req_op  = 4'b0000;
        req_idx = {3'd0, 3'd0, 3'd0, 3'd0};
        pulses  = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("held_gnt%0d", c), {28'd0, gnt},
                (c % 2 == 0) ? 32'h8 : 32'h0);
            if (gnt == 4'b1000) pulses++;
        end
        chk("held_pulses", pulses, 32'd3);
        chk_flags("held", 8'h00);
        req = '0;
        step();

        // Mid-operation reset during 4-way contention
        do_reset();
        req     = 4'b1111;
        req_op  = 4'b1111;
        req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        step();
        chk("mid_gnt0", {28'd0, gnt}, 32'h1);
        step();
        chk("mid_gnt1", {28'd0, gnt}, 32'h2);
        chk_flags("mid1", 8'h03);
        reset = 1'b1;
        step();
        chk("mid_rst_gnt", {28'd0, gnt}, 32'h0);
        chk_flags("mid_rst", 8'h00);
        reset = 1'b0;
        step();
        chk("mid_rel_gnt", {28'd0, gnt}, 32'h1);
        chk_flags("mid_rel", 8'h01);
        req = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
